instr_encoder: RTL and testbench

Packs instruction fields (cond, op, funct, Rn, Rd, src2/imm24) into 32-bit ARM-subset instruction words and writes them sequentially into instruction memory through a ready/valid-style write port. It is the writer-side counterpart of the processor's instruction decoder, and serves as the test/boot loader that fills instruction memory before the core runs. It only produces encodings the decoder and ALU implement; anything else is rejected with an error pulse.

---
 rtl/isa_pkg.sv | 26 ++
 rtl/instr_pack.sv | 31 +++
 rtl/instr_encoder.sv | 117 +++++++++++
 tb/tb_instr_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ARM-subset encoding constants and encoder FSM state type.
// The instruction decoder imports the same package so both ends agree on field values.
package isa_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } enc_state_t;

    function automatic logic is_alu_cmd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit instruction word and flags
// encodings that the decoder/ALU do not implement.
module instr_pack
    import isa_pkg::*;
(
    input  logic [3:0]  cond,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    input  logic [23:0] imm24,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = {cond, op, funct, rn, rd, src2};
        legal = 1'b0;
        case (op)
            OP_DP:   legal = is_alu_cmd(funct[4:1]);
            OP_MEM:  legal = 1'b1;
            OP_BR: begin
                word  = {cond, OP_BR, funct[5:4], imm24};
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Boot/test loader: encodes instruction requests and writes them sequentially
// into instruction memory, one word per accepted legal request.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic [11:0]       src2,
    input  logic [23:0]       imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              err,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic [31:0]       word_q, word_d;

    logic [31:0]       pack_word;
    logic              pack_legal;

    instr_pack u_pack (
        .cond  (cond),
        .op    (op),
        .funct (funct),
        .rn    (rn),
        .rd    (rd),
        .src2  (src2),
        .imm24 (imm24),
        .word  (pack_word),
        .legal (pack_legal)
    );

    // Decoded from registered state only; clear/reset mask it so a request
    // coinciding with either is never taken.
    assign req_ready = (state_q == S_IDLE) && !full_q && !clear && !reset;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        word_d   = word_q;
        err_d    = 1'b0;
        if (clear) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (pack_legal) begin
                            word_d  = pack_word;
                            state_d = S_WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                        if (wr_ptr_q == '1) full_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            err_q    <= err_d;
            word_q   <= word_d;
        end
    end

    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = wr_ptr_q;
    assign mem_wdata = word_q;
    assign err       = err_q;
    assign full      = full_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder with a small-memory (ADDR_W=2)
// configuration so fill, wrap and full behaviour are reached quickly.
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset, clear, req_valid, mem_ready;
    logic              req_ready, mem_we, err, full;
    logic [3:0]        cond, rn, rd;
    logic [1:0]        op;
    logic [5:0]        funct;
    logic [11:0]       src2;
    logic [23:0]       imm24;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;

    int checks   = 0;
    int failures = 0;

    // Reference state of the writer, tracked as plain integers.
    int m_ptr   = 0;
    int m_count = 0;
    int m_full  = 0;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .cond      (cond),
        .op        (op),
        .funct     (funct),
        .rn        (rn),
        .rd        (rd),
        .src2      (src2),
        .imm24     (imm24),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .err       (err),
        .full      (full),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input int o, input int f);
        int alu_cmds[4] = '{4, 2, 0, 12};
        int cmd;
        if (o == 3) return 1'b0;
        if (o != 0) return 1'b1;
        cmd = (f / 2) % 16;
        foreach (alu_cmds[i]) if (alu_cmds[i] == cmd) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint ref_word(input int c, input int o, input int f, input int n,
                                        input int d, input int s, input int imm);
        if (o == 2)
            return c * 64'd268435456 + 2 * 64'd67108864 + (f / 16) * 64'd16777216 + imm;
        return c * 64'd268435456 + o * 64'd67108864 + f * 64'd1048576 +
               n * 64'd65536 + d * 64'd4096 + s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_full = 0;
    endtask

    task automatic do_req(input int c, input int o, input int f, input int n, input int d,
                          input int s, input int imm, input int stall);
        longint w;
        bit     lg;
        w  = ref_word(c, o, f, n, d, s, imm);
        lg = ref_legal(o, f);
        cond = 4'(c); op = 2'(o); funct = 6'(f); rn = 4'(n); rd = 4'(d);
        src2 = 12'(s); imm24 = 24'(imm);
        req_valid = 1'b1;
        mem_ready = (stall == 0);
        #1;
        check("req_ready_idle", 64'(req_ready), 64'(m_full == 0));
        tick();
        req_valid = 1'b0;
        if (!lg) begin
            check("err_pulse", 64'(err), 64'd1);
            check("err_no_we", 64'(mem_we), 64'd0);
            mem_ready = 1'b0;
            tick();
            check("err_one_cycle", 64'(err), 64'd0);
            check("err_count", 64'(count), 64'(m_count));
            check("err_addr", 64'(mem_addr), 64'(m_ptr));
            return;
        end
        check("we_after_accept", 64'(mem_we), 64'd1);
        check("addr", 64'(mem_addr), 64'(m_ptr));
        check("wdata", 64'(mem_wdata), 64'(w));
        check("err_quiet", 64'(err), 64'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_we", 64'(mem_we), 64'd1);
            check("stall_addr", 64'(mem_addr), 64'(m_ptr));
            check("stall_wdata", 64'(mem_wdata), 64'(w));
            check("stall_count", 64'(count), 64'(m_count));
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        m_count++;
        m_ptr++;
        if (m_ptr == DEPTH) begin
            m_ptr  = 0;
            m_full = 1;
        end
        check("done_we", 64'(mem_we), 64'd0);
        check("done_count", 64'(count), 64'(m_count));
        check("done_full", 64'(full), 64'(m_full));
        check("done_ready", 64'(req_ready), 64'(m_full == 0));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        req_valid = 1'b1;
        #1;
        check("ready_during_clear", 64'(req_ready), 64'd0);
        tick();
        clear = 1'b0;
        req_valid = 1'b0;
        model_reset();
        check("clear_we", 64'(mem_we), 64'd0);
        check("clear_full", 64'(full), 64'd0);
        check("clear_count", 64'(count), 64'd0);
        check("clear_addr", 64'(mem_addr), 64'd0);
    endtask

    task automatic accept_only(input int imm);
        cond = 4'hE; op = 2'b10; funct = 6'b100000; imm24 = 24'(imm);
        rn = '0; rd = '0; src2 = '0;
        req_valid = 1'b1; mem_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        check("mid_we", 64'(mem_we), 64'd1);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; req_valid = 1'b0; mem_ready = 1'b0;
        cond = '0; op = '0; funct = '0; rn = '0; rd = '0; src2 = '0; imm24 = '0;
        tick();
        req_valid = 1'b1;
        tick();
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        reset = 1'b0; req_valid = 1'b0;
        tick();

        // ADD R1,R2,#5 ; LDR R3,[R0,#8] with a 3-cycle stall ; B -2
        do_req(14, 0, 6'b101000, 2, 1, 5, 0, 0);
        do_req(14, 1, 6'b011001, 0, 3, 8, 0, 3);
        do_req(14, 2, 6'b101111, 7, 7, 12'hABC, 24'hFFFFFE, 0);
        // op 11 and an unsupported ALU cmd
        do_req(14, 3, 6'b000000, 1, 1, 1, 0, 0);
        do_req(14, 0, 6'b000010, 1, 1, 1, 0, 0);
        // last slot: fills memory
        do_req(14, 0, 6'b011000, 4, 5, 12'h0FF, 0, 1);
        check("full_set", 64'(full), 64'd1);
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_ready", 64'(req_ready), 64'd0);
        do_clear();
        do_req(14, 0, 6'b001000, 3, 3, 12'h123, 0, 0);

        // clear during WRITE with mem_ready high aborts the write
        accept_only(24'h000010);
        clear = 1'b1; mem_ready = 1'b1;
        tick();
        clear = 1'b0; mem_ready = 1'b0;
        model_reset();
        check("clr_mid_we", 64'(mem_we), 64'd0);
        check("clr_mid_count", 64'(count), 64'd0);
        check("clr_mid_addr", 64'(mem_addr), 64'd0);

        // reset during WRITE
        do_req(14, 1, 6'b000001, 1, 2, 3, 0, 0);
        accept_only(24'h000020);
        reset = 1'b1;
        tick();
        check("rst_mid_we", 64'(mem_we), 64'd0);
        check("rst_mid_addr", 64'(mem_addr), 64'd0);
        check("rst_mid_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mid_count", 64'(count), 64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        model_reset();
        tick();

        for (int k = 0; k < 80; k++) begin
            if (m_full != 0) begin
                do_clear();
            end else begin
                do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 63)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
                       int'($urandom_range(0, 24'hFFFFFF)), int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
